// File: rtl/gpmc_dma_bridge.sv
// rtl/gpmc_dma_bridge.sv - GPMC-to-stream bridge with per-channel FIFOs and DMA requests
module gpmc_dma_bridge #(
  parameter int N_FROM     = 2,
  parameter int N_TO       = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int BURST      = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [9:0]             gpmc_a,
  input  logic [15:0]            gpmc_d_i,
  output logic [15:0]            gpmc_d_o,
  output logic                   gpmc_d_oe,
  input  logic                   gpmc_we_n,
  input  logic                   gpmc_oe_n,
  input  logic                   gpmc_ale_n,
  input  logic                   gpmc_dma_cs_n,
  output logic [N_FROM+N_TO-1:0] gpmc_dmareq_n,
  output logic [N_FROM-1:0]      s_from_stb,
  input  logic [N_FROM-1:0]      s_from_ack,
  output logic [16*N_FROM-1:0]   s_from_data,
  input  logic [N_TO-1:0]        s_to_stb,
  output logic [N_TO-1:0]        s_to_ack,
  input  logic [16*N_TO-1:0]     s_to_data,
  output logic [N_FROM-1:0]      ovf,
  output logic [N_TO-1:0]        unf,
  input  logic                   err_clr
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  // Full latched address; only the low nibble selects a channel.
  logic [25:0] ar;
  logic        we_n_q;
  logic        oe_n_q;
  logic [3:0]  ch;
  logic        wr_beat;
  logic        rd_pop;

  assign ch        = ar[3:0];
  assign wr_beat   = ~gpmc_dma_cs_n & gpmc_ale_n & we_n_q & ~gpmc_we_n;
  assign rd_pop    = ~gpmc_dma_cs_n & ~oe_n_q & gpmc_oe_n;
  assign gpmc_d_oe = ~gpmc_dma_cs_n & ~gpmc_oe_n & gpmc_ale_n;

  // Address latch and strobe history for edge detection on we_n / oe_n.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ar     <= '0;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
    end else begin
      if (!gpmc_ale_n) ar <= {gpmc_a, gpmc_d_i};
      we_n_q <= gpmc_we_n;
      oe_n_q <= gpmc_oe_n;
    end
  end

  // Host -> stream channels.
  for (genvar i = 0; i < N_FROM; i++) begin : g_from
    logic [15:0]           mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [CW-1:0]         cnt;
    logic                  sel;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  ovf_q;
    logic                  req_n_q;

    assign sel  = wr_beat && (ch == 4'(i));
    assign full = (cnt == DEPTH_C);
    assign push = sel & ~full;
    assign pop  = (cnt != '0) & s_from_ack[i];

    assign s_from_stb[i]          = (cnt != '0);
    assign s_from_data[16*i +: 16] = mem[rp];
    assign ovf[i]                 = ovf_q;
    assign gpmc_dmareq_n[i]       = req_n_q;

    // FIFO state, sticky overflow, and free-space DMA request.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        wp      <= '0;
        rp      <= '0;
        cnt     <= '0;
        ovf_q   <= 1'b0;
        req_n_q <= 1'b1;
      end else begin
        if (push) begin
          mem[wp] <= gpmc_d_i;
          wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
        if (err_clr)          ovf_q <= 1'b0;
        else if (sel && full) ovf_q <= 1'b1;
        req_n_q <= !((DEPTH_C - cnt) >= BURST_C);
      end
    end
  end

  // Stream -> host channels.
  logic [15:0]     to_head [N_TO];
  logic [N_TO-1:0] to_empty;

  for (genvar i = 0; i < N_TO; i++) begin : g_to
    logic [15:0]           mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [CW-1:0]         cnt;
    logic                  sel;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  unf_q;
    logic                  req_n_q;

    assign sel   = rd_pop && (ch == 4'(i));
    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);
    assign push  = s_to_stb[i] & s_to_ack[i];
    assign pop   = sel & ~empty;

    assign s_to_ack[i]              = ~full & ~sys_rst;
    assign to_head[i]               = mem[rp];
    assign to_empty[i]              = empty;
    assign unf[i]                   = unf_q;
    assign gpmc_dmareq_n[N_FROM+i]  = req_n_q;

    // FIFO state, sticky underflow, and fill-level DMA request.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        wp      <= '0;
        rp      <= '0;
        cnt     <= '0;
        unf_q   <= 1'b0;
        req_n_q <= 1'b1;
      end else begin
        if (push) begin
          mem[wp] <= s_to_data[16*i +: 16];
          wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
        if (err_clr)           unf_q <= 1'b0;
        else if (sel && empty) unf_q <= 1'b1;
        req_n_q <= !(cnt >= BURST_C);
      end
    end
  end

  // Head word of the addressed to-channel, zero when empty or out of range.
  logic [15:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_TO; k++) begin
      if (ch == 4'(k) && !to_empty[k]) rd_word = to_head[k];
    end
  end

  // Read data is registered every cycle, giving one cycle of latency.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) gpmc_d_o <= '0;
    else         gpmc_d_o <= rd_word;
  end

endmodule

// File: tb/tb_gpmc_dma_bridge.sv
// tb/tb_gpmc_dma_bridge.sv - scoreboard bench for gpmc_dma_bridge
module tb_gpmc_dma_bridge;

  localparam int NF = 2;
  localparam int NT = 2;
  localparam int DEPTH = 16;
  localparam int BURST = 8;

  typedef logic [15:0] word_q_t [$];

  logic              sys_clk = 0;
  logic              sys_rst;
  logic [9:0]        gpmc_a;
  logic [15:0]       gpmc_d_i;
  logic [15:0]       gpmc_d_o;
  logic              gpmc_d_oe;
  logic              gpmc_we_n;
  logic              gpmc_oe_n;
  logic              gpmc_ale_n;
  logic              gpmc_dma_cs_n;
  logic [NF+NT-1:0]  gpmc_dmareq_n;
  logic [NF-1:0]     s_from_stb;
  logic [NF-1:0]     s_from_ack;
  logic [16*NF-1:0]  s_from_data;
  logic [NT-1:0]     s_to_stb;
  logic [NT-1:0]     s_to_ack;
  logic [16*NT-1:0]  s_to_data;
  logic [NF-1:0]     ovf;
  logic [NT-1:0]     unf;
  logic              err_clr;

  int errors = 0;
  int checks = 0;
  bit ack_en = 0;

  word_q_t       exp_from [NF];
  word_q_t       to_q [NT];
  word_q_t       exp_rd;
  logic [NF-1:0] exp_ovf;
  logic [NT-1:0] exp_unf;

  gpmc_dma_bridge #(.N_FROM(NF), .N_TO(NT), .DEPTH_LOG2(4), .BURST(BURST)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gpmc_a(gpmc_a), .gpmc_d_i(gpmc_d_i),
    .gpmc_d_o(gpmc_d_o), .gpmc_d_oe(gpmc_d_oe), .gpmc_we_n(gpmc_we_n),
    .gpmc_oe_n(gpmc_oe_n), .gpmc_ale_n(gpmc_ale_n), .gpmc_dma_cs_n(gpmc_dma_cs_n),
    .gpmc_dmareq_n(gpmc_dmareq_n), .s_from_stb(s_from_stb), .s_from_ack(s_from_ack),
    .s_from_data(s_from_data), .s_to_stb(s_to_stb), .s_to_ack(s_to_ack),
    .s_to_data(s_to_data), .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_addr(input int c);
    gpmc_dma_cs_n = 0;
    gpmc_ale_n    = 0;
    gpmc_a        = 10'($urandom);
    gpmc_d_i      = {12'($urandom), 4'(c)};
    tick();
    gpmc_ale_n = 1;
  endtask

  // Host write; the reference decides store/drop from the model occupancy.
  task automatic host_write(input int c, input logic [15:0] d, input logic clr);
    set_addr(c);
    gpmc_d_i  = d;
    gpmc_we_n = 0;
    err_clr   = clr;
    if (c < NF) begin
      if (exp_from[c].size() == DEPTH) exp_ovf[c] = 1'b1;
      else exp_from[c].push_back(d);
    end
    if (clr) begin
      exp_ovf = '0;
      exp_unf = '0;
    end
    tick();
    gpmc_we_n = 1;
    err_clr   = 0;
    tick();
    gpmc_dma_cs_n = 1;
  endtask

  // Host read; the expected word goes to the scoreboard before the pop edge.
  task automatic host_read(input int c);
    logic [15:0] e;
    set_addr(c);
    gpmc_oe_n = 0;
    tick();
    chk("d_oe_during_read", gpmc_d_oe, 1);
    tick();
    e = 16'h0;
    if (c < NT) begin
      if (to_q[c].size() == 0) exp_unf[c] = 1'b1;
      else e = to_q[c].pop_front();
    end
    exp_rd.push_back(e);
    gpmc_oe_n = 1;
    tick();
    gpmc_dma_cs_n = 1;
  endtask

  task automatic stream_push(input int c, input logic [15:0] d);
    s_to_stb[c]            = 1'b1;
    s_to_data[16*c +: 16]  = d;
    chk("s_to_ack", s_to_ack[c], to_q[c].size() < DEPTH);
    if (to_q[c].size() < DEPTH) to_q[c].push_back(d);
    tick();
    s_to_stb[c] = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NF; i++) exp_from[i].delete();
    for (int i = 0; i < NT; i++) to_q[i].delete();
    exp_rd.delete();
    exp_ovf = '0;
    exp_unf = '0;
  endtask

  function automatic logic [NF+NT-1:0] model_req();
    logic [NF+NT-1:0] r;
    for (int i = 0; i < NF; i++) r[i] = !((DEPTH - exp_from[i].size()) >= BURST);
    for (int i = 0; i < NT; i++) r[NF+i] = !(to_q[i].size() >= BURST);
    return r;
  endfunction

  // Random stream-out back-pressure while enabled.
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (ack_en) s_from_ack = NF'($urandom);
  end

  // Monitor: pops the scoreboard whenever the DUT hands out a word.
  initial begin
    logic oe_prev;
    logic [15:0] e;
    oe_prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        for (int i = 0; i < NF; i++) begin
          if (exp_from[i].size() == 0) chk("from_stb_idle", s_from_stb[i], 0);
          else if (s_from_stb[i] && s_from_ack[i]) begin
            e = exp_from[i].pop_front();
            chk("from_data", s_from_data[16*i +: 16], e);
          end
        end
        if (!gpmc_dma_cs_n && !oe_prev && gpmc_oe_n) begin
          if (exp_rd.size() == 0) chk("rd_unexpected_pop", gpmc_oe_n, 0);
          else begin
            e = exp_rd.pop_front();
            chk("rd_data", gpmc_d_o, e);
          end
        end
      end
      oe_prev = gpmc_oe_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1; gpmc_a = 0; gpmc_d_i = 0; gpmc_we_n = 1; gpmc_oe_n = 1;
    gpmc_ale_n = 1; gpmc_dma_cs_n = 1; s_from_ack = 0; s_to_stb = 0;
    s_to_data = 0; err_clr = 0;
    clear_model();
    tick(); tick();

    // Reset values.
    chk("rst_stb", s_from_stb, 0);
    chk("rst_to_ack", s_to_ack, 0);
    chk("rst_dmareq", gpmc_dmareq_n, 4'hF);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_d_o", gpmc_d_o, 0);
    chk("rst_d_oe", gpmc_d_oe, 0);
    sys_rst = 0;
    tick();
    chk("post_rst_to_ack", s_to_ack, 2'b11);
    chk("post_rst_dmareq", gpmc_dmareq_n, 4'b1100);

    // Single write to ch0, visible next cycle, popped by ack.
    host_write(0, 16'h1234, 0);
    chk("ch0_stb", s_from_stb[0], 1);
    chk("ch0_data", s_from_data[15:0], 16'h1234);
    s_from_ack[0] = 1; tick(); s_from_ack[0] = 0; tick();
    chk("ch0_stb_after_pop", s_from_stb[0], 0);

    // Overflow on ch1, clear, clear-beats-set, drain in order.
    for (int k = 0; k < 17; k++) host_write(1, 16'($urandom), 0);
    chk("ovf_set", ovf, exp_ovf);
    chk("ovf_set_bit1", ovf[1], 1);
    chk("full_dmareq1", gpmc_dmareq_n[1], 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("ovf_cleared", ovf, 0);
    host_write(1, 16'hBEEF, 1);
    chk("ovf_clr_priority", ovf, exp_ovf);
    s_from_ack[1] = 1;
    repeat (18) tick();
    s_from_ack[1] = 0;
    tick();
    chk("ch1_drained", exp_from[1].size(), 0);
    chk("ch1_stb_empty", s_from_stb[1], 0);

    // To-ch0 burst threshold and in-order host reads.
    for (int k = 0; k < 8; k++) stream_push(0, 16'hA000 + 16'(k));
    chk("to0_req_before", gpmc_dmareq_n[NF], 1);
    tick();
    chk("to0_req_asserted", gpmc_dmareq_n[NF], 0);
    host_read(0);
    chk("to0_req_hold", gpmc_dmareq_n[NF], 0);
    tick();
    chk("to0_req_released", gpmc_dmareq_n[NF], 1);
    for (int k = 0; k < 7; k++) host_read(0);
    chk("to0_all_read", exp_rd.size(), 0);

    // From-ch0 free-space threshold.
    chk("from0_req_empty", gpmc_dmareq_n[0], 0);
    for (int k = 0; k < 8; k++) host_write(0, 16'($urandom), 0);
    chk("from0_req_free8", gpmc_dmareq_n[0], 0);
    host_write(0, 16'($urandom), 0);
    chk("from0_req_free7", gpmc_dmareq_n[0], 1);
    s_from_ack[0] = 1; repeat (12) tick(); s_from_ack[0] = 0; tick();
    chk("from0_drained", exp_from[0].size(), 0);

    // Underflow and out-of-range read.
    host_read(1);
    chk("unf_set", unf, exp_unf);
    chk("unf_set_bit1", unf[1], 1);
    host_read(15);
    chk("unf_ch15_no_flag", unf, exp_unf);

    // Reset in the middle of a burst.
    for (int k = 0; k < 8; k++) host_write(0, 16'($urandom), 0);
    for (int k = 0; k < 5; k++) stream_push(1, 16'($urandom));
    sys_rst = 1;
    clear_model();
    tick();
    chk("midrst_stb", s_from_stb, 0);
    chk("midrst_dmareq", gpmc_dmareq_n, 4'hF);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_unf", unf, 0);
    chk("midrst_to_ack", s_to_ack, 0);
    sys_rst = 0;
    tick();
    chk("midrst_after_to_ack", s_to_ack, 2'b11);
    chk("midrst_after_dmareq", gpmc_dmareq_n, 4'b1100);
    host_read(1);
    chk("midrst_to1_empty_unf", unf, exp_unf);

    // Randomised traffic against the queue model.
    err_clr = 1; tick(); err_clr = 0;
    exp_ovf = '0; exp_unf = '0;
    ack_en = 1;
    for (int it = 0; it < 250; it++) begin
      int op;
      int c;
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          c = int'($urandom_range(0, 3));
          if (c >= NF || exp_from[c].size() < DEPTH - 3) host_write(c, 16'($urandom), 0);
        end
        1: stream_push(int'($urandom_range(0, NT - 1)), 16'($urandom));
        2: begin
          c = int'($urandom_range(0, 4));
          host_read(c == 4 ? 15 : c);
        end
        default: tick();
      endcase
    end
    ack_en = 0;
    tick();
    s_from_ack = 0;
    repeat (3) tick();
    chk("rand_dmareq", gpmc_dmareq_n, model_req());
    chk("rand_ovf", ovf, exp_ovf);
    chk("rand_unf", unf, exp_unf);
    s_from_ack = '1;
    repeat (20) tick();
    s_from_ack = 0;
    tick();
    for (int i = 0; i < NF; i++) chk("rand_from_drained", exp_from[i].size(), 0);
    for (int i = 0; i < NT; i++) begin
      while (to_q[i].size() > 0) host_read(i);
    end
    tick();
    chk("rand_rd_drained", exp_rd.size(), 0);
    chk("final_dmareq", gpmc_dmareq_n, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
